// File: rtl/uart_rx.sv
// Oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined).
// Samples each bit at its centre using the baud generator's tick strobe.
module uart_rx #(
  parameter int OVERSAMPLING = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);
  localparam int TW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLING/2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_n;
  logic                 rx_meta, rxs;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] sr;
  logic                 smp_half, smp_full, perr;

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign smp_half = tick && (tcnt == T_HALF);
  assign smp_full = tick && (tcnt == T_FULL);
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (!rxs) state_n = START;
      START: if (smp_half) state_n = rxs ? IDLE : DATA;
      DATA:
        if (smp_full && bcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      PARITY: if (smp_full) state_n = STOP;
`endif
      STOP:  if (smp_full) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par;
  assign perr = ^{sr, par};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           par <= 1'b0;
    else if (state == PARITY && smp_full) par <= rxs;
  end
`else
  assign perr       = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      bcnt      <= '0;
      sr        <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // Any transition restarts the tick count, so an IDLE->START tick is dropped.
      if (state_n != state) tcnt <= '0;
      else if (tick)        tcnt <= tcnt + 1'b1;

      if (state != DATA && state_n == DATA)           bcnt <= '0;
      else if (state == DATA && smp_full && bcnt != B_LAST) bcnt <= bcnt + 1'b1;

      if (state == DATA && smp_full) sr <= {rxs, sr[DATA_BITS-1:1]};

      if (state == STOP && smp_full) begin
        if (!rxs) frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
        else if (perr) parity_err <= 1'b1;
`endif
        else begin
          data  <= sr;
          valid <= 1'b1;
        end
      end
    end
  end

  logic unused;
  assign unused = perr;
endmodule
